drm_activation_ctrl_stub: RTL and testbench
===========================================

Name: drm_activation_ctrl_stub

Overview:
Parametrised controller stub that replaces the DRM Controller BFM for simulation and co-simulation. It drives activation codes into NB_CHANNELS DRM Activators from a license-load handshake. It models locked/demo, permanent and timed (metered) licenses with expiry, renewal and revocation, and optionally emits event pulses when ENABLE_DRM_MESSAGE=1. It sits between the testbench/license loader and the activator activation-code inputs, and is fully synthesizable.

Parameters:
NB_CHANNELS, 4, number of activator channels (1..16)
CODE_WIDTH, 128, activation code width per channel
TIMER_WIDTH, 32, width of license duration counter
DEMO_CYCLES, 1024, demo-mode window after reset per channel (0 = no demo)
LOAD_LATENCY, 8, cycles from cfg accept to code application (>=1)
ENABLE_DRM_MESSAGE, 0, 1 = event outputs active; 0 = event outputs tied 0

Ports:
drm_aclk  in  1  clock
drm_arstn  in  1  synchronous active-low reset
cfg_valid  in  1  license load request
cfg_ready  out  1  loader free to accept
cfg_channel  in  4  target channel index
cfg_mode  in  2  0=REVOKE, 1=PERMANENT, 2=TIMED, 3=reserved (treated as REVOKE)
cfg_code  in  CODE_WIDTH  activation code
cfg_duration  in  TIMER_WIDTH  TIMED license length in cycles
cfg_err  out  1  1-cycle pulse: bad channel index
activation_code  out  NB_CHANNELS*CODE_WIDTH  per-channel code, channel i at bits [i*CODE_WIDTH +: CODE_WIDTH]
activation_code_ready  out  NB_CHANNELS  channel licensed
demo_mode  out  NB_CHANNELS  channel in demo window
evt_activated  out  NB_CHANNELS  1-cycle pulse on LOCKED/EXPIRED->ACTIVE
evt_expired  out  NB_CHANNELS  1-cycle pulse on TIMED expiry
evt_demo_end  out  NB_CHANNELS  1-cycle pulse when demo window ends

Behaviour:
- Reset (drm_arstn=0 at a clock edge): all channels LOCKED, codes 0, ready 0, demo counters=DEMO_CYCLES, demo_mode=(DEMO_CYCLES!=0), cfg_ready=1, all pulses 0, pending load cleared. Reset mid-load aborts the load silently.
- Handshake: transfer when cfg_valid&&cfg_ready. cfg_ready falls the cycle after the transfer and stays 0 for LOAD_LATENCY cycles. The request is applied on the cycle the pending counter reaches 0; cfg_ready returns to 1 in that same cycle, so there is one load in flight at a time.
- cfg_channel>=NB_CHANNELS: transfer accepted, cfg_err pulses the next cycle, no pending load, cfg_ready stays 1.
- REVOKE is applied immediately (no latency): channel ->LOCKED, code=0, ready=0, no event. The demo counter is not reloaded.
- Per-channel FSM: LOCKED, ACTIVE_PERM, ACTIVE_TIMED, EXPIRED.
  - LOCKED/EXPIRED + PERMANENT/TIMED applied -> ACTIVE_*: code latched, ready=1, evt_activated pulses the same cycle.
  - ACTIVE_* + PERMANENT/TIMED applied (renewal) -> new ACTIVE_*: code replaced, ready stays 1, no evt_activated. A TIMED renewal reloads the timer.
  - ACTIVE_TIMED: the timer loads cfg_duration and decrements each cycle. When it reads 1 and no renewal lands that cycle -> EXPIRED next cycle: ready=0, code=0, evt_expired pulses. A renewal landing on the expiry cycle wins: no expiry, no pulse.
  - TIMED with cfg_duration=0 is treated as 1: active one cycle, then expiry.
- Demo: the counter decrements while the channel is LOCKED and the count is >0. It freezes (does not decrement) in ACTIVE_*/EXPIRED. demo_mode = LOCKED && count!=0. On the 1->0 transition, evt_demo_end pulses once. EXPIRED never asserts demo_mode.
- Channels are independent; simultaneous events on several channels all pulse in the same cycle.
- ENABLE_DRM_MESSAGE=0: evt_* constant 0. cfg_err is unaffected.
- All outputs are registered; no combinational path from cfg_* to outputs except cfg_ready (registered as well).

Test Plan:
1. Reset with DEMO_CYCLES=16 and no loads -> demo_mode=4'hF for 16 cycles, then 0 with evt_demo_end=4'hF for one cycle; activation_code_ready=0 throughout.
2. PERMANENT load to ch2, code=128'hA5..A5 -> cfg_ready low for 8 cycles; on cycle 9 after the transfer, ready[2]=1, code slice 2=A5..A5, evt_activated[2] pulses; ch0/1/3 unchanged.
3. TIMED ch1, duration=20 -> ready[1] high exactly 20 cycles, then 0, code slice 0, evt_expired[1] pulses once.
4. TIMED ch1, duration=10, with a TIMED renewal (duration=10) timed to apply on the expiry cycle -> ready[1] never drops, no evt_expired, no second evt_activated, expires 10 cycles later.
5. cfg_channel=7 with NB_CHANNELS=4 -> cfg_err pulses, cfg_ready stays 1, no channel changes. REVOKE on an ACTIVE ch0 -> ready[0]=0 the next cycle; demo_mode[0] resumes only if its demo count was >0.
6. drm_arstn low for one cycle during the LOAD_LATENCY of a ch3 load -> after reset, ch3 stays LOCKED, cfg_ready=1, no evt_activated.

Source files
------------

// File: rtl/drm_activation_ctrl_stub.sv
// drm_activation_ctrl_stub: simulation stand-in for the DRM controller.
// Drives per-channel activation codes from a license-load handshake and models
// locked/demo, permanent and timed licenses with expiry, renewal and revocation.
module drm_activation_ctrl_stub #(
    parameter int unsigned NB_CHANNELS        = 4,
    parameter int unsigned CODE_WIDTH         = 128,
    parameter int unsigned TIMER_WIDTH        = 32,
    parameter int unsigned DEMO_CYCLES        = 1024,
    parameter int unsigned LOAD_LATENCY       = 8,
    parameter int unsigned ENABLE_DRM_MESSAGE = 0
) (
    input  logic                              drm_aclk,
    input  logic                              drm_arstn,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [3:0]                        cfg_channel,
    input  logic [1:0]                        cfg_mode,
    input  logic [CODE_WIDTH-1:0]             cfg_code,
    input  logic [TIMER_WIDTH-1:0]            cfg_duration,
    output logic                              cfg_err,
    output logic [NB_CHANNELS*CODE_WIDTH-1:0] activation_code,
    output logic [NB_CHANNELS-1:0]            activation_code_ready,
    output logic [NB_CHANNELS-1:0]            demo_mode,
    output logic [NB_CHANNELS-1:0]            evt_activated,
    output logic [NB_CHANNELS-1:0]            evt_expired,
    output logic [NB_CHANNELS-1:0]            evt_demo_end
);

    localparam int unsigned DEMO_W = (DEMO_CYCLES == 0) ? 1 : $clog2(DEMO_CYCLES + 1);
    localparam int unsigned LAT_W  = (LOAD_LATENCY < 2) ? 1 : $clog2(LOAD_LATENCY + 1);

    localparam logic [1:0] MODE_PERM  = 2'd1;
    localparam logic [1:0] MODE_TIMED = 2'd2;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_PERM    = 2'd1,
        ST_TIMED   = 2'd2,
        ST_EXPIRED = 2'd3
    } ch_state_e;

    ch_state_e              state_q [NB_CHANNELS];
    ch_state_e              state_d [NB_CHANNELS];
    logic [CODE_WIDTH-1:0]  code_q  [NB_CHANNELS];
    logic [CODE_WIDTH-1:0]  code_d  [NB_CHANNELS];
    logic [TIMER_WIDTH-1:0] timer_q [NB_CHANNELS];
    logic [TIMER_WIDTH-1:0] timer_d [NB_CHANNELS];
    logic [DEMO_W-1:0]      demo_q  [NB_CHANNELS];
    logic [DEMO_W-1:0]      demo_d  [NB_CHANNELS];

    logic [NB_CHANNELS-1:0] ready_q, ready_d;
    logic [NB_CHANNELS-1:0] demo_mode_q, demo_mode_d;
    logic [NB_CHANNELS-1:0] evt_activated_q, evt_activated_d;
    logic [NB_CHANNELS-1:0] evt_expired_q, evt_expired_d;
    logic [NB_CHANNELS-1:0] evt_demo_end_q, evt_demo_end_d;

    logic                   cfg_ready_q, cfg_ready_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [LAT_W-1:0]       pend_cnt_q, pend_cnt_d;
    logic [3:0]             pend_ch_q, pend_ch_d;
    logic                   pend_timed_q, pend_timed_d;
    logic [CODE_WIDTH-1:0]  pend_code_q, pend_code_d;
    logic [TIMER_WIDTH-1:0] pend_dur_q, pend_dur_d;

    logic accept;
    logic bad_ch;
    logic is_load;
    logic apply;

    assign accept  = cfg_valid && cfg_ready_q;
    assign bad_ch  = {1'b0, cfg_channel} >= 5'(NB_CHANNELS);
    assign is_load = (cfg_mode == MODE_PERM) || (cfg_mode == MODE_TIMED);
    assign apply   = (pend_cnt_q == LAT_W'(1));

    // Loader handshake, per-channel license FSMs, timers and demo counters.
    always_comb begin
        cfg_ready_d     = cfg_ready_q;
        cfg_err_d       = 1'b0;
        pend_cnt_d      = pend_cnt_q;
        pend_ch_d       = pend_ch_q;
        pend_timed_d    = pend_timed_q;
        pend_code_d     = pend_code_q;
        pend_dur_d      = pend_dur_q;
        ready_d         = '0;
        demo_mode_d     = '0;
        evt_activated_d = '0;
        evt_expired_d   = '0;
        evt_demo_end_d  = '0;
        for (int i = 0; i < NB_CHANNELS; i++) begin
            state_d[i] = state_q[i];
            code_d[i]  = code_q[i];
            timer_d[i] = timer_q[i];
            demo_d[i]  = demo_q[i];
        end

        // Single in-flight load; the apply cycle also reopens the loader.
        if (pend_cnt_q != '0) begin
            if (apply) begin
                pend_cnt_d  = '0;
                cfg_ready_d = 1'b1;
            end else begin
                pend_cnt_d = pend_cnt_q - LAT_W'(1);
            end
        end else if (accept && !bad_ch && is_load) begin
            pend_cnt_d   = LAT_W'(LOAD_LATENCY);
            pend_ch_d    = cfg_channel;
            pend_timed_d = (cfg_mode == MODE_TIMED);
            pend_code_d  = cfg_code;
            pend_dur_d   = (cfg_duration == '0) ? TIMER_WIDTH'(1) : cfg_duration;
            cfg_ready_d  = 1'b0;
        end
        cfg_err_d = accept && bad_ch;

        for (int i = 0; i < NB_CHANNELS; i++) begin
            // Demo window only runs while locked.
            if (state_q[i] == ST_LOCKED && demo_q[i] != '0) begin
                demo_d[i] = demo_q[i] - DEMO_W'(1);
                if (demo_q[i] == DEMO_W'(1)) begin
                    evt_demo_end_d[i] = 1'b1;
                end
            end

            if (state_q[i] == ST_TIMED) begin
                if (timer_q[i] == TIMER_WIDTH'(1)) begin
                    state_d[i]       = ST_EXPIRED;
                    code_d[i]        = '0;
                    evt_expired_d[i] = 1'b1;
                end else begin
                    timer_d[i] = timer_q[i] - TIMER_WIDTH'(1);
                end
            end

            // A landing load overrides a same-cycle expiry (renewal wins).
            if (apply && pend_ch_q == 4'(i)) begin
                evt_expired_d[i] = 1'b0;
                if (state_q[i] == ST_LOCKED || state_q[i] == ST_EXPIRED) begin
                    evt_activated_d[i] = 1'b1;
                end
                state_d[i] = pend_timed_q ? ST_TIMED : ST_PERM;
                code_d[i]  = pend_code_q;
                timer_d[i] = pend_dur_q;
            end

            // Revoke (and reserved mode) takes effect on the accept cycle.
            if (accept && !bad_ch && !is_load && cfg_channel == 4'(i)) begin
                state_d[i]       = ST_LOCKED;
                code_d[i]        = '0;
                timer_d[i]       = '0;
                evt_expired_d[i] = 1'b0;
            end

            ready_d[i]     = (state_d[i] == ST_PERM) || (state_d[i] == ST_TIMED);
            demo_mode_d[i] = (state_d[i] == ST_LOCKED) && (demo_d[i] != '0);
        end

        if (ENABLE_DRM_MESSAGE == 0) begin
            evt_activated_d = '0;
            evt_expired_d   = '0;
            evt_demo_end_d  = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge drm_aclk) begin
        if (!drm_arstn) begin
            for (int i = 0; i < NB_CHANNELS; i++) begin
                state_q[i] <= ST_LOCKED;
                code_q[i]  <= '0;
                timer_q[i] <= '0;
                demo_q[i]  <= DEMO_W'(DEMO_CYCLES);
            end
            ready_q         <= '0;
            demo_mode_q     <= {NB_CHANNELS{DEMO_CYCLES != 0}};
            evt_activated_q <= '0;
            evt_expired_q   <= '0;
            evt_demo_end_q  <= '0;
            cfg_ready_q     <= 1'b1;
            cfg_err_q       <= 1'b0;
            pend_cnt_q      <= '0;
            pend_ch_q       <= '0;
            pend_timed_q    <= 1'b0;
            pend_code_q     <= '0;
            pend_dur_q      <= '0;
        end else begin
            for (int i = 0; i < NB_CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                code_q[i]  <= code_d[i];
                timer_q[i] <= timer_d[i];
                demo_q[i]  <= demo_d[i];
            end
            ready_q         <= ready_d;
            demo_mode_q     <= demo_mode_d;
            evt_activated_q <= evt_activated_d;
            evt_expired_q   <= evt_expired_d;
            evt_demo_end_q  <= evt_demo_end_d;
            cfg_ready_q     <= cfg_ready_d;
            cfg_err_q       <= cfg_err_d;
            pend_cnt_q      <= pend_cnt_d;
            pend_ch_q       <= pend_ch_d;
            pend_timed_q    <= pend_timed_d;
            pend_code_q     <= pend_code_d;
            pend_dur_q      <= pend_dur_d;
        end
    end

    // Flatten per-channel code registers onto the activator bus.
    always_comb begin
        activation_code = '0;
        for (int i = 0; i < NB_CHANNELS; i++) begin
            activation_code[i*CODE_WIDTH +: CODE_WIDTH] = code_q[i];
        end
    end

    assign cfg_ready             = cfg_ready_q;
    assign cfg_err               = cfg_err_q;
    assign activation_code_ready = ready_q;
    assign demo_mode             = demo_mode_q;
    assign evt_activated         = evt_activated_q;
    assign evt_expired           = evt_expired_q;
    assign evt_demo_end          = evt_demo_end_q;

endmodule

// File: tb/tb_drm_activation_ctrl_stub.sv
// Bench for drm_activation_ctrl_stub: directed sequences, a vector table and
// random traffic, all checked against a cycle-timestamp license model.
module tb_drm_activation_ctrl_stub;

    localparam int NB   = 4;
    localparam int CW   = 128;
    localparam int TW   = 32;
    localparam int DEMO = 16;
    localparam int LAT  = 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [3:0]      cfg_channel = '0;
    logic [1:0]      cfg_mode = '0;
    logic [CW-1:0]   cfg_code = '0;
    logic [TW-1:0]   cfg_duration = '0;

    logic            cfg_ready, cfg_err;
    logic [NB*CW-1:0] activation_code;
    logic [NB-1:0]   code_ready, demo_mode, evt_act, evt_exp, evt_demo;

    logic            nm_cfg_ready, nm_cfg_err;
    logic [NB*CW-1:0] nm_code;
    logic [NB-1:0]   nm_ready, nm_demo, nm_act, nm_exp, nm_dend;

    int total = 0;
    int bad   = 0;

    drm_activation_ctrl_stub #(
        .NB_CHANNELS(NB), .CODE_WIDTH(CW), .TIMER_WIDTH(TW), .DEMO_CYCLES(DEMO),
        .LOAD_LATENCY(LAT), .ENABLE_DRM_MESSAGE(1)
    ) dut (
        .drm_aclk(clk), .drm_arstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_channel(cfg_channel), .cfg_mode(cfg_mode), .cfg_code(cfg_code),
        .cfg_duration(cfg_duration), .cfg_err(cfg_err), .activation_code(activation_code),
        .activation_code_ready(code_ready), .demo_mode(demo_mode), .evt_activated(evt_act),
        .evt_expired(evt_exp), .evt_demo_end(evt_demo)
    );

    drm_activation_ctrl_stub #(
        .NB_CHANNELS(NB), .CODE_WIDTH(CW), .TIMER_WIDTH(TW), .DEMO_CYCLES(DEMO),
        .LOAD_LATENCY(LAT), .ENABLE_DRM_MESSAGE(0)
    ) dut_nm (
        .drm_aclk(clk), .drm_arstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(nm_cfg_ready),
        .cfg_channel(cfg_channel), .cfg_mode(cfg_mode), .cfg_code(cfg_code),
        .cfg_duration(cfg_duration), .cfg_err(nm_cfg_err), .activation_code(nm_code),
        .activation_code_ready(nm_ready), .demo_mode(nm_demo), .evt_activated(nm_act),
        .evt_expired(nm_exp), .evt_demo_end(nm_dend)
    );

    always #5 clk = ~clk;

    // Reference model: licenses carry an absolute end cycle, loads an absolute apply cycle.
    longint          cyc = 0;
    bit              m_active  [NB];
    bit              m_expired [NB];
    logic [CW-1:0]   m_code    [NB];
    longint          m_end     [NB];
    int              m_demo    [NB];
    bit              m_pend = 1'b0;
    longint          m_pend_at = 0;
    int              m_pend_ch = 0;
    bit              m_pend_timed = 1'b0;
    logic [CW-1:0]   m_pend_code = '0;
    longint          m_pend_dur = 0;
    bit              m_cfg_ready = 1'b1;
    bit              m_err = 1'b0;
    bit [NB-1:0]     m_ev_act = '0, m_ev_exp = '0, m_ev_demo = '0;

    always @(posedge clk) begin : model
        bit was_ready;
        bit land;
        bit locked_before;
        int ch;
        cyc = cyc + 1;
        if (!rstn) begin
            for (int c = 0; c < NB; c++) begin
                m_active[c] = 1'b0; m_expired[c] = 1'b0; m_code[c] = '0;
                m_end[c] = 0; m_demo[c] = DEMO;
            end
            m_pend = 1'b0; m_cfg_ready = 1'b1; m_err = 1'b0;
            m_ev_act = '0; m_ev_exp = '0; m_ev_demo = '0;
        end else begin
            was_ready = m_cfg_ready;
            m_err = 1'b0; m_ev_act = '0; m_ev_exp = '0; m_ev_demo = '0;
            for (int c = 0; c < NB; c++) begin
                locked_before = !m_active[c] && !m_expired[c];
                if (locked_before && m_demo[c] > 0) begin
                    m_demo[c] = m_demo[c] - 1;
                    if (m_demo[c] == 0) m_ev_demo[c] = 1'b1;
                end
            end
            land = m_pend && (m_pend_at == cyc);
            for (int c = 0; c < NB; c++) begin
                if (land && m_pend_ch == c) begin
                    if (!m_active[c]) m_ev_act[c] = 1'b1;
                    m_active[c] = 1'b1; m_expired[c] = 1'b0; m_code[c] = m_pend_code;
                    m_end[c] = m_pend_timed ? cyc + ((m_pend_dur == 0) ? 1 : m_pend_dur) : 0;
                end else if (m_active[c] && m_end[c] != 0 && m_end[c] == cyc) begin
                    m_active[c] = 1'b0; m_expired[c] = 1'b1; m_code[c] = '0;
                    m_ev_exp[c] = 1'b1;
                end
            end
            if (land) begin
                m_pend = 1'b0; m_cfg_ready = 1'b1;
            end
            if (cfg_valid && was_ready) begin
                ch = int'(cfg_channel);
                if (ch >= NB) begin
                    m_err = 1'b1;
                end else if (cfg_mode == 2'd1 || cfg_mode == 2'd2) begin
                    m_pend = 1'b1; m_pend_at = cyc + LAT; m_pend_ch = ch;
                    m_pend_timed = (cfg_mode == 2'd2); m_pend_code = cfg_code;
                    m_pend_dur = longint'(cfg_duration); m_cfg_ready = 1'b0;
                end else begin
                    m_active[ch] = 1'b0; m_expired[ch] = 1'b0; m_code[ch] = '0;
                    m_end[ch] = 0; m_ev_exp[ch] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [NB-1:0]    er, ed;
        logic [NB*CW-1:0] ec;
        for (int c = 0; c < NB; c++) begin
            er[c] = m_active[c];
            ed[c] = !m_active[c] && !m_expired[c] && (m_demo[c] > 0);
            ec[c*CW +: CW] = m_code[c];
        end
        chk("model_ready",     512'(code_ready),      512'(er));
        chk("model_code",      512'(activation_code), 512'(ec));
        chk("model_demo",      512'(demo_mode),       512'(ed));
        chk("model_cfg_ready", 512'(cfg_ready),       512'(m_cfg_ready));
        chk("model_cfg_err",   512'(cfg_err),         512'(m_err));
        chk("model_evt_act",   512'(evt_act),         512'(m_ev_act));
        chk("model_evt_exp",   512'(evt_exp),         512'(m_ev_exp));
        chk("model_evt_demo",  512'(evt_demo),        512'(m_ev_demo));
        chk("nomsg_evts",      512'({nm_act, nm_exp, nm_dend}), 512'(0));
        chk("nomsg_cfg_err",   512'(nm_cfg_err),      512'(m_err));
        chk("nomsg_ready",     512'(nm_ready),        512'(er));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("cfg_ready_timeout", 512'(n >= 50), 512'(0));
    endtask

    task automatic send(input int ch, input int mode, input logic [CW-1:0] code, input int dur);
        wait_ready();
        cfg_valid = 1'b1; cfg_channel = 4'(ch); cfg_mode = 2'(mode);
        cfg_code = code; cfg_duration = TW'(dur);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rstn = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rstn = 1'b1;
    endtask

    typedef struct {
        int          ch;
        int          mode;
        logic [7:0]  cbyte;
        int          dur;
        logic [NB-1:0] exp_ready;
        logic        exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [CW-1:0] ca5, c3, c4a, c4b, cexp;
        int wslice;
        tbl[0] = '{0, 1, 8'h11, 0,    4'b0001, 1'b0};
        tbl[1] = '{1, 2, 8'h22, 1000, 4'b0011, 1'b0};
        tbl[2] = '{9, 1, 8'h33, 0,    4'b0011, 1'b1};
        tbl[3] = '{0, 0, 8'h00, 0,    4'b0010, 1'b0};
        tbl[4] = '{3, 3, 8'h00, 0,    4'b0010, 1'b0};
        tbl[5] = '{3, 2, 8'h55, 1000, 4'b1010, 1'b0};
        tbl[6] = '{1, 1, 8'h66, 0,    4'b1010, 1'b0};
        tbl[7] = '{2, 1, 8'h77, 0,    4'b1110, 1'b0};
        tbl[8] = '{15, 0, 8'h00, 0,   4'b1110, 1'b1};
        tbl[9] = '{1, 3, 8'h00, 0,    4'b1100, 1'b0};

        ca5 = {16{8'hA5}};
        c3  = {16{8'h3C}};
        c4a = {16{8'h4A}};
        c4b = {16{8'h4B}};

        // Demo window after reset with no loads.
        do_reset(2);
        chk("rst_cfg_ready", 512'(cfg_ready), 512'(1));
        chk("rst_code", 512'(activation_code), 512'(0));
        for (int k = 1; k < DEMO; k++) begin
            chk("demo_on", 512'(demo_mode), 512'(4'hF));
            chk("demo_noready", 512'(code_ready), 512'(0));
            step();
        end
        chk("demo_last", 512'(demo_mode), 512'(4'hF));
        step();
        chk("demo_off", 512'(demo_mode), 512'(0));
        chk("demo_end_evt", 512'(evt_demo), 512'(4'hF));
        step();
        chk("demo_end_once", 512'(evt_demo), 512'(0));

        // Permanent load latency on channel 2.
        send(2, 1, ca5, 0);
        for (int k = 0; k < LAT - 1; k++) begin
            chk("lat_cfg_ready_low", 512'(cfg_ready), 512'(0));
            chk("lat_not_applied", 512'(code_ready), 512'(0));
            step();
        end
        chk("lat_cfg_ready_low", 512'(cfg_ready), 512'(0));
        step();
        chk("perm_ready", 512'(code_ready), 512'(4'b0100));
        chk("perm_code", 512'(activation_code[2*CW +: CW]), 512'(ca5));
        chk("perm_others", 512'({activation_code[3*CW +: CW], activation_code[0 +: 2*CW]}), 512'(0));
        chk("perm_evt_act", 512'(evt_act), 512'(4'b0100));
        chk("perm_cfg_ready", 512'(cfg_ready), 512'(1));
        step();
        chk("perm_evt_once", 512'(evt_act), 512'(0));

        // Timed license of 20 cycles on channel 1.
        send(1, 2, c3, 20);
        for (int k = 0; k < LAT; k++) step();
        for (int k = 0; k < 20; k++) begin
            chk("timed_on", 512'(code_ready[1]), 512'(1));
            step();
        end
        chk("timed_off", 512'(code_ready[1]), 512'(0));
        chk("timed_code_clr", 512'(activation_code[1*CW +: CW]), 512'(0));
        chk("timed_evt_exp", 512'(evt_exp), 512'(4'b0010));
        step();
        chk("timed_evt_once", 512'(evt_exp), 512'(0));

        // Renewal landing on the expiry cycle.
        send(1, 2, c4a, 10);
        for (int k = 0; k < LAT; k++) step();
        chk("renew_first_act", 512'(evt_act), 512'(4'b0010));
        step();
        send(1, 2, c4b, 10);
        for (int k = 3; k < 20; k++) begin
            step();
            chk("renew_held", 512'(code_ready[1]), 512'(1));
            chk("renew_no_exp", 512'(evt_exp), 512'(0));
            chk("renew_no_act", 512'(evt_act), 512'(0));
        end
        chk("renew_code", 512'(activation_code[1*CW +: CW]), 512'(c4b));
        step();
        chk("renew_expired", 512'(code_ready[1]), 512'(0));
        chk("renew_evt_exp", 512'(evt_exp), 512'(4'b0010));

        // Bad channel index.
        step();
        send(7, 1, c3, 0);
        chk("bad_ch_err", 512'(cfg_err), 512'(1));
        chk("bad_ch_cfg_ready", 512'(cfg_ready), 512'(1));
        chk("bad_ch_unchanged", 512'(code_ready), 512'(4'b0100));
        step();
        chk("bad_ch_err_once", 512'(cfg_err), 512'(0));

        // Revoke on an active channel whose demo window still has time left.
        do_reset(1);
        send(0, 1, c3, 0);
        for (int k = 0; k < LAT; k++) step();
        chk("pre_revoke_ready", 512'(code_ready), 512'(4'b0001));
        chk("pre_revoke_demo", 512'(demo_mode), 512'(4'b1110));
        send(0, 0, '0, 0);
        chk("revoke_ready", 512'(code_ready), 512'(0));
        chk("revoke_code", 512'(activation_code[0 +: CW]), 512'(0));
        chk("revoke_demo_resume", 512'(demo_mode), 512'(4'hF));
        chk("revoke_no_evt", 512'(evt_act | evt_exp), 512'(0));

        // Reset during the latency of a channel 3 load.
        send(3, 1, ca5, 0);
        for (int k = 0; k < 3; k++) step();
        do_reset(1);
        chk("midrst_cfg_ready", 512'(cfg_ready), 512'(1));
        chk("midrst_ready", 512'(code_ready), 512'(0));
        for (int k = 0; k < LAT + 2; k++) begin
            step();
            chk("midrst_locked", 512'(code_ready[3]), 512'(0));
            chk("midrst_no_act", 512'(evt_act), 512'(0));
        end

        // Vector table.
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].ch, tbl[i].mode, {16{tbl[i].cbyte}}, tbl[i].dur);
            chk($sformatf("tbl%0d_err", i), 512'(cfg_err), 512'(tbl[i].exp_err));
            wait_ready();
            chk($sformatf("tbl%0d_ready", i), 512'(code_ready), 512'(tbl[i].exp_ready));
            if (tbl[i].ch < NB) begin
                wslice = tbl[i].ch;
                cexp = tbl[i].exp_ready[wslice] ? {16{tbl[i].cbyte}} : '0;
                chk($sformatf("tbl%0d_code", i), 512'(activation_code[wslice*CW +: CW]), 512'(cexp));
            end
        end

        // Random traffic against the model.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            rstn         = ($urandom_range(0, 399) != 0);
            cfg_valid    = ($urandom_range(0, 2) == 0);
            cfg_channel  = 4'($urandom_range(0, 5));
            cfg_mode     = 2'($urandom_range(0, 3));
            cfg_code     = {$urandom, $urandom, $urandom, $urandom};
            cfg_duration = TW'($urandom_range(0, 30));
            step();
        end
        cfg_valid = 1'b0;
        rstn = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
